// File: rtl/secuenciador_division.sv
// secuenciador_division
// ---------------------------------------------------------------------------
// Control FSM that sits between operand capture and the divider / bin2bcd /
// display chain. A rising edge on operands_ready captures A/B. The FSM then
// pulses the divider, waits for its result with a timeout, and pulses the
// bin-to-BCD converter with either the quotient or the remainder. It also
// handles divide-by-zero and the quotient/remainder display toggle.
//
// Handshake semantics: this block has no valid/ready pairs. Every exchange is
// a one-cycle pulse. div_start and bcd_start are single-cycle requests. Their
// data (div_dividendo/div_divisor, bcd_bin) is stable from the pulse until
// the matching done pulse arrives. div_done and bcd_done are single-cycle
// completions. They are honoured only in the matching wait state; at any other
// time they are ignored.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   operands_ready, a_in, b_in operand capture level and operands
//   sel_toggle                 pulse: swap the displayed value (quotient/remainder)
//   div_start, div_dividendo,
//   div_divisor                divider request
//   div_done, div_cociente,
//   div_resto                  divider completion and results
//   bcd_start, bcd_bin         bin2bcd request
//   bcd_done                   bin2bcd completion
//   busy, result_valid         status flags
//   show_resto                 0 = quotient shown, 1 = remainder shown
//   err_div0, err_timeout      sticky error flags
//   state_dbg                  current FSM state encoding
// ---------------------------------------------------------------------------
module secuenciador_division #(
  parameter int W           = 7,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         operands_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         sel_toggle,
  output logic         div_start,
  output logic [W-1:0] div_dividendo,
  output logic [W-1:0] div_divisor,
  input  logic         div_done,
  input  logic [W-1:0] div_cociente,
  input  logic [W-1:0] div_resto,
  output logic         bcd_start,
  output logic [W-1:0] bcd_bin,
  input  logic         bcd_done,
  output logic         busy,
  output logic         result_valid,
  output logic         show_resto,
  output logic         err_div0,
  output logic         err_timeout,
  output logic [2:0]   state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LATCH     = 3'd1,
    S_DIV_GO    = 3'd2,
    S_DIV_WAIT  = 3'd3,
    S_CONV_GO   = 3'd4,
    S_CONV_WAIT = 3'd5,
    S_SHOW      = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_t         state, state_nx;
  logic           ready_d;
  logic           new_ops;
  logic           limit;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   a_reg, b_reg, q_reg, r_reg;
  logic [W-1:0]   bcd_bin_reg;
  logic           bcd_start_reg;
  logic           show_resto_reg;
  logic           err_div0_reg, err_timeout_reg;

  assign new_ops = operands_ready & ~ready_d;
  // The counter is cleared on entry to a wait state. In the k-th cycle of the
  // wait state it holds k. The last cycle in which a done pulse is accepted is
  // therefore the one where cnt == TIMEOUT_CYC-1.
  assign limit   = (cnt == CW'(TIMEOUT_CYC - 1));

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:      if (new_ops) state_nx = S_LATCH;
      S_LATCH:     state_nx = (b_in == '0) ? S_ERROR : S_DIV_GO;
      S_DIV_GO:    state_nx = S_DIV_WAIT;
      S_DIV_WAIT: begin
        if (div_done)   state_nx = S_CONV_GO;
        else if (limit) state_nx = S_ERROR;
      end
      S_CONV_GO:   state_nx = S_CONV_WAIT;
      S_CONV_WAIT: begin
        if (bcd_done)   state_nx = S_SHOW;
        else if (limit) state_nx = S_ERROR;
      end
      // new_ops has priority over a coincident sel_toggle.
      S_SHOW: begin
        if (new_ops)         state_nx = S_LATCH;
        else if (sel_toggle) state_nx = S_CONV_GO;
      end
      S_ERROR:     if (new_ops) state_nx = S_LATCH;
      default:     state_nx = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Datapath, counter and flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_d         <= 1'b0;
      cnt             <= '0;
      a_reg           <= '0;
      b_reg           <= '0;
      q_reg           <= '0;
      r_reg           <= '0;
      bcd_bin_reg     <= '0;
      bcd_start_reg   <= 1'b0;
      show_resto_reg  <= 1'b0;
      err_div0_reg    <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      ready_d       <= operands_ready;
      bcd_start_reg <= 1'b0;
      unique case (state)
        S_LATCH: begin
          a_reg           <= a_in;
          b_reg           <= b_in;
          err_div0_reg    <= (b_in == '0);
          err_timeout_reg <= 1'b0;
        end
        S_DIV_GO: cnt <= '0;
        S_DIV_WAIT: begin
          cnt <= cnt + 1'b1;
          if (div_done) begin
            q_reg <= div_cociente;
            r_reg <= div_resto;
          end else if (limit) begin
            err_timeout_reg <= 1'b1;
          end
        end
        // bcd_bin is loaded here from the already-updated show_resto. The
        // start pulse is registered so that it coincides with valid data.
        // This puts bcd_start two cycles after div_done.
        S_CONV_GO: begin
          cnt           <= '0;
          bcd_bin_reg   <= show_resto_reg ? r_reg : q_reg;
          bcd_start_reg <= 1'b1;
        end
        S_CONV_WAIT: begin
          cnt <= cnt + 1'b1;
          if (!bcd_done && limit) err_timeout_reg <= 1'b1;
        end
        S_SHOW: begin
          if (!new_ops && sel_toggle) show_resto_reg <= ~show_resto_reg;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  assign div_start     = (state == S_DIV_GO);
  assign div_dividendo = a_reg;
  assign div_divisor   = b_reg;
  assign bcd_start     = bcd_start_reg;
  assign bcd_bin       = bcd_bin_reg;
  assign busy          = (state == S_LATCH)   || (state == S_DIV_GO) ||
                         (state == S_DIV_WAIT) || (state == S_CONV_GO) ||
                         (state == S_CONV_WAIT);
  assign result_valid  = (state == S_SHOW);
  assign show_resto    = show_resto_reg;
  assign err_div0      = err_div0_reg;
  assign err_timeout   = err_timeout_reg;
  assign state_dbg     = state;

endmodule

// File: tb/tb_secuenciador_division.sv
// tb_secuenciador_division
// ---------------------------------------------------------------------------
// Directed bench for secuenciador_division. Each scenario task drives the
// operands and the divider/bin2bcd response pulses itself and compares the DUT
// outputs against hand-computed values. All inputs change 1 ns after the
// rising edge, and the outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_secuenciador_division;

  localparam int W = 7;
  localparam logic [2:0] S_IDLE = 3'd0, S_LATCH = 3'd1, S_DIV_GO = 3'd2,
                         S_DIV_WAIT = 3'd3, S_CONV_GO = 3'd4, S_CONV_WAIT = 3'd5,
                         S_SHOW = 3'd6, S_ERROR = 3'd7;

  logic         clk = 1'b0;
  logic         rst;
  logic         operands_ready, sel_toggle, div_done, bcd_done;
  logic [W-1:0] a_in, b_in, div_cociente, div_resto;
  logic         div_start, bcd_start, busy, result_valid, show_resto;
  logic         err_div0, err_timeout;
  logic [W-1:0] div_dividendo, div_divisor, bcd_bin;
  logic [2:0]   state_dbg;

  int checks = 0;
  int errors = 0;
  int div_starts = 0;
  int bcd_starts = 0;

  secuenciador_division #(.W(W), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .operands_ready(operands_ready), .a_in(a_in), .b_in(b_in),
    .sel_toggle(sel_toggle), .div_start(div_start), .div_dividendo(div_dividendo),
    .div_divisor(div_divisor), .div_done(div_done), .div_cociente(div_cociente),
    .div_resto(div_resto), .bcd_start(bcd_start), .bcd_bin(bcd_bin), .bcd_done(bcd_done),
    .busy(busy), .result_valid(result_valid), .show_resto(show_resto),
    .err_div0(err_div0), .err_timeout(err_timeout), .state_dbg(state_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (div_start === 1'b1) div_starts++;
    if (bcd_start === 1'b1) bcd_starts++;
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1 ns after an edge: the current cycle becomes cycle E.
  task automatic present(input logic [W-1:0] a, input logic [W-1:0] b);
    a_in = a;
    b_in = b;
    operands_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    operands_ready = 1'b0; sel_toggle = 1'b0; div_done = 1'b0; bcd_done = 1'b0;
    a_in = '0; b_in = '0; div_cociente = '0; div_resto = '0;
    step(); step();
    checks++; if ({div_start, bcd_start, busy, result_valid, show_resto, err_div0, err_timeout} !== 7'd0) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000000", {div_start, bcd_start, busy, result_valid, show_resto, err_div0, err_timeout}); end
    checks++; if ({div_dividendo, div_divisor, bcd_bin} !== 21'd0) begin
      errors++; $display("FAIL reset_data got=%h exp=0", {div_dividendo, div_divisor, bcd_bin}); end
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, S_IDLE); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_divide();
    present(7'd100, 7'd7);
    step(); // E+1
    checks++; if (state_dbg !== S_LATCH || busy !== 1'b1) begin
      errors++; $display("FAIL div_latch state=%0d busy=%b exp state=%0d busy=1", state_dbg, busy, S_LATCH); end
    step(); // E+2
    checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL div_start_e2 got=%b exp=1", div_start); end
    checks++; if (div_dividendo !== 7'd100 || div_divisor !== 7'd7) begin
      errors++; $display("FAIL div_operands got=%0d/%0d exp=100/7", div_dividendo, div_divisor); end
    step(); // E+3
    operands_ready = 1'b0;
    checks++; if (div_start !== 1'b0 || state_dbg !== S_DIV_WAIT) begin
      errors++; $display("FAIL div_wait start=%b state=%0d exp start=0 state=%0d", div_start, state_dbg, S_DIV_WAIT); end
    repeat (7) step(); // E+10
    div_done = 1'b1; div_cociente = 7'd14; div_resto = 7'd2;
    step(); // D+1
    div_done = 1'b0;
    checks++; if (state_dbg !== S_CONV_GO || bcd_start !== 1'b0) begin
      errors++; $display("FAIL conv_go state=%0d bcd_start=%b exp state=%0d bcd_start=0", state_dbg, bcd_start, S_CONV_GO); end
    step(); // D+2
    checks++; if (bcd_start !== 1'b1 || bcd_bin !== 7'd14) begin
      errors++; $display("FAIL bcd_start_q bcd_start=%b bcd_bin=%0d exp 1/14", bcd_start, bcd_bin); end
    repeat (3) step();
    bcd_done = 1'b1;
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rv_early got=%b exp=0", result_valid); end
    step();
    bcd_done = 1'b0;
    checks++; if (result_valid !== 1'b1 || busy !== 1'b0 || show_resto !== 1'b0 || state_dbg !== S_SHOW) begin
      errors++; $display("FAIL show_q rv=%b busy=%b sr=%b state=%0d exp 1/0/0/%0d", result_valid, busy, show_resto, state_dbg, S_SHOW); end
  endtask

  task automatic test_toggle(input logic exp_resto, input logic [W-1:0] exp_bin);
    int start_cnt;
    sel_toggle = 1'b1;
    step();
    sel_toggle = 1'b0;
    start_cnt = bcd_starts;
    checks++; if (result_valid !== 1'b0 || show_resto !== exp_resto || state_dbg !== S_CONV_GO) begin
      errors++; $display("FAIL toggle rv=%b sr=%b state=%0d exp 0/%b/%0d", result_valid, show_resto, state_dbg, exp_resto, S_CONV_GO); end
    step();
    checks++; if (bcd_start !== 1'b1 || bcd_bin !== exp_bin) begin
      errors++; $display("FAIL toggle_bcd bcd_start=%b bcd_bin=%0d exp 1/%0d", bcd_start, bcd_bin, exp_bin); end
    repeat (4) step();
    bcd_done = 1'b1;
    step();
    bcd_done = 1'b0;
    checks++; if (result_valid !== 1'b1 || state_dbg !== S_SHOW) begin
      errors++; $display("FAIL toggle_show rv=%b state=%0d exp 1/%0d", result_valid, state_dbg, S_SHOW); end
    checks++; if (bcd_starts - start_cnt !== 1) begin
      errors++; $display("FAIL toggle_pulses got=%0d exp=1", bcd_starts - start_cnt); end
  endtask

  task automatic test_div_zero();
    int ds;
    ds = div_starts;
    present(7'd50, 7'd0);
    step(); // E+1
    step(); // E+2
    operands_ready = 1'b0;
    checks++; if (state_dbg !== S_ERROR || err_div0 !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL div0 state=%0d err_div0=%b busy=%b exp %0d/1/0", state_dbg, err_div0, busy, S_ERROR); end
    sel_toggle = 1'b1;
    step();
    sel_toggle = 1'b0;
    checks++; if (show_resto !== 1'b0 || state_dbg !== S_ERROR) begin
      errors++; $display("FAIL err_toggle sr=%b state=%0d exp 0/%0d", show_resto, state_dbg, S_ERROR); end
    step();
    checks++; if (div_starts !== ds) begin errors++; $display("FAIL div0_nostart got=%0d exp=%0d", div_starts, ds); end
    present(7'd9, 7'd3);
    step(); step(); // E+2
    checks++; if (err_div0 !== 1'b0 || div_start !== 1'b1 || div_dividendo !== 7'd9) begin
      errors++; $display("FAIL div0_clear err=%b start=%b dvd=%0d exp 0/1/9", err_div0, div_start, div_dividendo); end
    step();
    operands_ready = 1'b0;
    step();
    div_done = 1'b1; div_cociente = 7'd3; div_resto = 7'd0;
    step();
    div_done = 1'b0;
    step();
    checks++; if (bcd_bin !== 7'd3 || bcd_start !== 1'b1) begin
      errors++; $display("FAIL div0_next bcd_bin=%0d start=%b exp 3/1", bcd_bin, bcd_start); end
    step();
    bcd_done = 1'b1;
    step();
    bcd_done = 1'b0;
    checks++; if (state_dbg !== S_SHOW) begin errors++; $display("FAIL div0_show state=%0d exp=%0d", state_dbg, S_SHOW); end
  endtask

  task automatic test_timeout();
    int bs;
    present(7'd20, 7'd4);
    step(); step(); step(); // E+3, first DIV_WAIT cycle
    operands_ready = 1'b0;
    bs = bcd_starts;
    repeat (63) step(); // entry+63
    checks++; if (err_timeout !== 1'b0 || busy !== 1'b1 || state_dbg !== S_DIV_WAIT) begin
      errors++; $display("FAIL to_early err=%b busy=%b state=%0d exp 0/1/%0d", err_timeout, busy, state_dbg, S_DIV_WAIT); end
    step(); // entry+64
    checks++; if (err_timeout !== 1'b1 || busy !== 1'b0 || state_dbg !== S_ERROR) begin
      errors++; $display("FAIL to_flag err=%b busy=%b state=%0d exp 1/0/%0d", err_timeout, busy, state_dbg, S_ERROR); end
    repeat (4) step();
    checks++; if (bcd_starts !== bs || result_valid !== 1'b0) begin
      errors++; $display("FAIL to_nobcd pulses=%0d rv=%b exp %0d/0", bcd_starts, result_valid, bs); end
  endtask

  task automatic test_done_at_limit();
    present(7'd100, 7'd10);
    step(); step();
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_clear got=%b exp=0", err_timeout); end
    step(); // first DIV_WAIT cycle
    operands_ready = 1'b0;
    repeat (63) step(); // last cycle before the timeout fires
    div_done = 1'b1; div_cociente = 7'd10; div_resto = 7'd0;
    step();
    div_done = 1'b0;
    checks++; if (state_dbg !== S_CONV_GO || err_timeout !== 1'b0) begin
      errors++; $display("FAIL limit_done state=%0d err=%b exp %0d/0", state_dbg, err_timeout, S_CONV_GO); end
    step();
    checks++; if (bcd_bin !== 7'd10) begin errors++; $display("FAIL limit_bin got=%0d exp=10", bcd_bin); end
    step();
    bcd_done = 1'b1;
    step();
    bcd_done = 1'b0;
  endtask

  task automatic test_back_to_back();
    int ds;
    ds = div_starts;
    present(7'd30, 7'd5);
    step(); step(); step(); // DIV_WAIT
    operands_ready = 1'b0;
    step();
    present(7'd99, 7'd9);
    step(); step();
    checks++; if (state_dbg !== S_DIV_WAIT || div_dividendo !== 7'd30 || div_divisor !== 7'd5) begin
      errors++; $display("FAIL b2b_ignore state=%0d ops=%0d/%0d exp %0d 30/5", state_dbg, div_dividendo, div_divisor, S_DIV_WAIT); end
    operands_ready = 1'b0;
    div_done = 1'b1; div_cociente = 7'd6; div_resto = 7'd0;
    step();
    div_done = 1'b0;
    step();
    checks++; if (bcd_bin !== 7'd6) begin errors++; $display("FAIL b2b_bin got=%0d exp=6", bcd_bin); end
    checks++; if (div_starts - ds !== 1) begin errors++; $display("FAIL b2b_starts got=%0d exp=1", div_starts - ds); end
    step();
    bcd_done = 1'b1;
    step();
    bcd_done = 1'b0;
    checks++; if (state_dbg !== S_SHOW) begin errors++; $display("FAIL b2b_show state=%0d exp=%0d", state_dbg, S_SHOW); end
  endtask

  task automatic test_reset_mid();
    present(7'd45, 7'd6);
    step(); step(); step();
    operands_ready = 1'b0;
    div_done = 1'b1; div_cociente = 7'd7; div_resto = 7'd3;
    step();
    div_done = 1'b0;
    step(); // first CONV_WAIT cycle
    checks++; if (state_dbg !== S_CONV_WAIT || bcd_bin !== 7'd7) begin
      errors++; $display("FAIL rm_pre state=%0d bin=%0d exp %0d/7", state_dbg, bcd_bin, S_CONV_WAIT); end
    step();
    #2 rst = 1'b0;
    #1;
    checks++; if ({div_start, bcd_start, busy, result_valid, show_resto, err_div0, err_timeout} !== 7'd0 ||
                  {div_dividendo, div_divisor, bcd_bin} !== 21'd0 || state_dbg !== S_IDLE) begin
      errors++; $display("FAIL rm_async flags=%b data=%h state=%0d exp 0/0/%0d",
        {div_start, bcd_start, busy, result_valid, show_resto, err_div0, err_timeout},
        {div_dividendo, div_divisor, bcd_bin}, state_dbg, S_IDLE); end
    step();
    rst = 1'b1;
    step();
    bcd_done = 1'b1; div_done = 1'b1;
    step();
    bcd_done = 1'b0; div_done = 1'b0;
    checks++; if (state_dbg !== S_IDLE || busy !== 1'b0 || bcd_start !== 1'b0 || result_valid !== 1'b0) begin
      errors++; $display("FAIL rm_stray state=%0d busy=%b bs=%b rv=%b exp %0d/0/0/0", state_dbg, busy, bcd_start, result_valid, S_IDLE); end
    step();
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL rm_idle state=%0d exp=%0d", state_dbg, S_IDLE); end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_toggle(1'b1, 7'd2);
    test_toggle(1'b0, 7'd14);
    test_div_zero();
    test_timeout();
    test_done_at_limit();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
